pio_pin_ctrl: RTL and testbench

Clocked, parametrised pin-mapping stage between the PIO state machine and the pad ring.
- Replaces the latch-based, 32-pin-only mapping with registered output/direction state and configurable input synchronisers.
- Supports multi-bit side-set with an optional enable bit, SET and OUT writes to pins or pindirs, and pin-index wrap-around.
- Tri-state pad buffers live outside this block; it drives pad_out/pad_oe and samples pad_in.

---
 rtl/pio_pkg.sv | 63 ++++++
 rtl/pio_in_sync.sv | 36 +++
 rtl/pio_pin_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pio_pin_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// -----------------------------------------------------------------------------
// pio_pkg
// Shared constants, the write-request record and the window helpers used by
// the PIO pin-mapping stage.
//   window_mask(base, count, npins) : npins-wide mask of the pins covered by a
//                                     window of `count` pins starting at `base`,
//                                     wrapping modulo npins; count saturates at
//                                     npins and 0 selects nothing.
//   place(data, base, npins)        : rotates LSB-aligned field data so that
//                                     field bit i lands on pin (base+i) % npins.
// -----------------------------------------------------------------------------
package pio_pkg;

    localparam int PIO_MAX_PINS = 32;
    localparam int PIO_SET_W    = 5;
    localparam int PIO_SS_MAX   = 5;

    // One pin-space write: which pins it touches and the values they receive.
    typedef struct packed {
        logic [PIO_MAX_PINS-1:0] mask;
        logic [PIO_MAX_PINS-1:0] vals;
    } pio_wr_t;

    function automatic logic [PIO_MAX_PINS-1:0] window_mask(
        input logic [4:0] base,
        input logic [5:0] count,
        input int         npins
    );
        logic [PIO_MAX_PINS-1:0] m;
        int                      cnt;
        int                      idx;
        m   = '0;
        cnt = int'(count);
        if (cnt > npins) begin
            cnt = npins;
        end
        for (int i = 0; i < PIO_MAX_PINS; i++) begin
            if (i < cnt) begin
                idx         = (int'(base) + i) % npins;
                m[idx[4:0]] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [PIO_MAX_PINS-1:0] place(
        input logic [PIO_MAX_PINS-1:0] data,
        input logic [4:0]              base,
        input int                      npins
    );
        logic [PIO_MAX_PINS-1:0] r;
        int                      idx;
        r = '0;
        for (int i = 0; i < PIO_MAX_PINS; i++) begin
            if (i < npins) begin
                idx         = (int'(base) + i) % npins;
                r[idx[4:0]] = data[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pio_in_sync.sv
// -----------------------------------------------------------------------------
// pio_in_sync
// Per-bit input synchroniser bank with individual bypass.
//   clk_i      : clock
//   rst_ni     : asynchronous active-low reset, clears every synchroniser flop
//   bypass_i   : per-bit bypass; a set bit routes d_i straight to q_o
//   d_i        : raw asynchronous inputs
//   q_o        : synchronised (SYNC_STAGES cycles late) or bypassed inputs
// -----------------------------------------------------------------------------
module pio_in_sync #(
    parameter int NUM_PINS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_PINS-1:0] bypass_i,
    input  logic [NUM_PINS-1:0] d_i,
    output logic [NUM_PINS-1:0] q_o
);

    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] stage_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign q_o = (bypass_i & d_i) | (~bypass_i & stage_q[SYNC_STAGES-1]);

endmodule

// File: rtl/pio_pin_ctrl.sv
// -----------------------------------------------------------------------------
// pio_pin_ctrl
// Registered pin-mapping stage between a PIO state machine and the pad ring.
// Output values and output enables are held in flops; OUT, SET and side-set
// writes are merged into them through wrapping pin windows. Inputs are passed
// through a configurable synchroniser bank and windowed into in_data.
//
// Ports
//   clock, reset_n          : clock, asynchronous active-low reset
//   cfg_in_base/count       : IN window (rotate-right + low-bit mask)
//   cfg_out_base/count      : OUT window
//   cfg_set_base/count      : SET window (up to 5 pins)
//   cfg_ss_base/count       : side-set window, count includes the enable bit
//   cfg_ss_opt              : side-set MSB is an enable bit
//   cfg_ss_pindirs          : side-set targets pad_oe instead of pad_out
//   cfg_sync_bypass         : per-pin synchroniser bypass
//   out_valid/dirs/data     : OUT write strobe, target select, LSB-aligned data
//   set_valid/dirs/data     : SET write strobe, target select, data
//   ss_valid/ss_data        : side-set present this cycle, LSB-aligned field
//   pad_in                  : raw pad inputs
//   pad_out, pad_oe         : registered pin values and output enables
//   in_data                 : windowed input data, zero-extended to 32 bits
// -----------------------------------------------------------------------------
module pio_pin_ctrl
    import pio_pkg::*;
#(
    parameter int NUM_PINS    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int PIN_W       = $clog2(NUM_PINS)
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic [PIN_W-1:0]    cfg_in_base,
    input  logic [5:0]          cfg_in_count,
    input  logic [PIN_W-1:0]    cfg_out_base,
    input  logic [5:0]          cfg_out_count,
    input  logic [PIN_W-1:0]    cfg_set_base,
    input  logic [2:0]          cfg_set_count,
    input  logic [PIN_W-1:0]    cfg_ss_base,
    input  logic [2:0]          cfg_ss_count,
    input  logic                cfg_ss_opt,
    input  logic                cfg_ss_pindirs,
    input  logic [NUM_PINS-1:0] cfg_sync_bypass,

    input  logic                out_valid,
    input  logic                out_dirs,
    input  logic [31:0]         out_data,
    input  logic                set_valid,
    input  logic                set_dirs,
    input  logic [4:0]          set_data,
    input  logic                ss_valid,
    input  logic [4:0]          ss_data,

    input  logic [NUM_PINS-1:0] pad_in,
    output logic [NUM_PINS-1:0] pad_out,
    output logic [NUM_PINS-1:0] pad_oe,
    output logic [31:0]         in_data
);

    // ------------------------------------------------------------------
    // Base indices widened to the 5-bit form the window helpers take.
    // ------------------------------------------------------------------
    logic [4:0] in_base5;
    logic [4:0] out_base5;
    logic [4:0] set_base5;
    logic [4:0] ss_base5;

    assign in_base5  = 5'(cfg_in_base);
    assign out_base5 = 5'(cfg_out_base);
    assign set_base5 = 5'(cfg_set_base);
    assign ss_base5  = 5'(cfg_ss_base);

    // ------------------------------------------------------------------
    // Input path: synchronise, then rotate the window down to bit 0.
    // ------------------------------------------------------------------
    logic [NUM_PINS-1:0] synced;

    pio_in_sync #(
        .NUM_PINS    (NUM_PINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_sync (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .bypass_i (cfg_sync_bypass),
        .d_i      (pad_in),
        .q_o      (synced)
    );

    always_comb begin
        int in_cnt;
        int idx;
        in_data = '0;
        idx     = 0;
        in_cnt  = int'(cfg_in_count);
        if (in_cnt > NUM_PINS) begin
            in_cnt = NUM_PINS;
        end
        // rotate-right by base then mask to count: bit i is pin (base+i) % N
        for (int i = 0; i < PIO_MAX_PINS; i++) begin
            if (i < in_cnt) begin
                idx        = (int'(in_base5) + i) % NUM_PINS;
                in_data[i] = synced[idx[PIN_W-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Side-set decode. With the optional enable, the top field bit gates
    // the write and only the bits below it carry data.
    // ------------------------------------------------------------------
    logic [2:0] ss_cnt;
    logic [2:0] ss_bits;
    logic       ss_apply;

    assign ss_cnt = (cfg_ss_count > 3'(PIO_SS_MAX)) ? 3'(PIO_SS_MAX) : cfg_ss_count;

    always_comb begin
        ss_apply = 1'b0;
        ss_bits  = '0;
        if (ss_valid && (ss_cnt != 3'd0)) begin
            if (cfg_ss_opt) begin
                ss_apply = ss_data[ss_cnt - 3'd1];
                ss_bits  = ss_cnt - 3'd1;
            end else begin
                ss_apply = 1'b1;
                ss_bits  = ss_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write requests in pin space.
    // ------------------------------------------------------------------
    logic [2:0] set_cnt;
    pio_wr_t    wr_out;
    pio_wr_t    wr_set;
    pio_wr_t    wr_ss;

    assign set_cnt = (cfg_set_count > 3'(PIO_SET_W)) ? 3'(PIO_SET_W) : cfg_set_count;

    assign wr_out.mask = window_mask(out_base5, cfg_out_count, NUM_PINS);
    assign wr_out.vals = place(out_data, out_base5, NUM_PINS);

    assign wr_set.mask = window_mask(set_base5, {3'b000, set_cnt}, NUM_PINS);
    assign wr_set.vals = place({27'b0, set_data}, set_base5, NUM_PINS);

    assign wr_ss.mask  = window_mask(ss_base5, {3'b000, ss_bits}, NUM_PINS);
    assign wr_ss.vals  = place({27'b0, ss_data}, ss_base5, NUM_PINS);

    function automatic logic [NUM_PINS-1:0] merge(
        input logic [NUM_PINS-1:0] cur,
        input logic [NUM_PINS-1:0] vals,
        input logic [NUM_PINS-1:0] mask
    );
        return (cur & ~mask) | (vals & mask);
    endfunction

    // ------------------------------------------------------------------
    // Next-state merge. Writes are applied lowest priority first so a later
    // write overrides an earlier one on overlapping pins of the same target;
    // writes to different targets land independently.
    // ------------------------------------------------------------------
    logic [NUM_PINS-1:0] pad_out_q, pad_out_d;
    logic [NUM_PINS-1:0] pad_oe_q,  pad_oe_d;

    always_comb begin
        pad_out_d = pad_out_q;
        pad_oe_d  = pad_oe_q;

        if (out_valid) begin
            if (out_dirs) begin
                pad_oe_d  = merge(pad_oe_d,  wr_out.vals[NUM_PINS-1:0], wr_out.mask[NUM_PINS-1:0]);
            end else begin
                pad_out_d = merge(pad_out_d, wr_out.vals[NUM_PINS-1:0], wr_out.mask[NUM_PINS-1:0]);
            end
        end

        if (set_valid) begin
            if (set_dirs) begin
                pad_oe_d  = merge(pad_oe_d,  wr_set.vals[NUM_PINS-1:0], wr_set.mask[NUM_PINS-1:0]);
            end else begin
                pad_out_d = merge(pad_out_d, wr_set.vals[NUM_PINS-1:0], wr_set.mask[NUM_PINS-1:0]);
            end
        end

        if (ss_apply) begin
            if (cfg_ss_pindirs) begin
                pad_oe_d  = merge(pad_oe_d,  wr_ss.vals[NUM_PINS-1:0], wr_ss.mask[NUM_PINS-1:0]);
            end else begin
                pad_out_d = merge(pad_out_d, wr_ss.vals[NUM_PINS-1:0], wr_ss.mask[NUM_PINS-1:0]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pad_out_q <= '0;
            pad_oe_q  <= '0;
        end else begin
            pad_out_q <= pad_out_d;
            pad_oe_q  <= pad_oe_d;
        end
    end

    assign pad_out = pad_out_q;
    assign pad_oe  = pad_oe_q;

endmodule

// File: tb/tb_pio_pin_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pio_pin_ctrl
// Directed bench for pio_pin_ctrl (NUM_PINS=32, SYNC_STAGES=2). Expected pin
// state is kept in m_out/m_oe, pushed to a scoreboard when stimulus is driven
// and popped after the following clock edge.
// -----------------------------------------------------------------------------
module tb_pio_pin_ctrl;

    localparam int NP = 32;
    localparam int SS = 2;

    logic          clock;
    logic          reset_n;
    logic [4:0]    cfg_in_base;
    logic [5:0]    cfg_in_count;
    logic [4:0]    cfg_out_base;
    logic [5:0]    cfg_out_count;
    logic [4:0]    cfg_set_base;
    logic [2:0]    cfg_set_count;
    logic [4:0]    cfg_ss_base;
    logic [2:0]    cfg_ss_count;
    logic          cfg_ss_opt;
    logic          cfg_ss_pindirs;
    logic [NP-1:0] cfg_sync_bypass;
    logic          out_valid;
    logic          out_dirs;
    logic [31:0]   out_data;
    logic          set_valid;
    logic          set_dirs;
    logic [4:0]    set_data;
    logic          ss_valid;
    logic [4:0]    ss_data;
    logic [NP-1:0] pad_in;
    logic [NP-1:0] pad_out;
    logic [NP-1:0] pad_oe;
    logic [31:0]   in_data;

    pio_pin_ctrl #(
        .NUM_PINS    (NP),
        .SYNC_STAGES (SS)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cfg_in_base     (cfg_in_base),
        .cfg_in_count    (cfg_in_count),
        .cfg_out_base    (cfg_out_base),
        .cfg_out_count   (cfg_out_count),
        .cfg_set_base    (cfg_set_base),
        .cfg_set_count   (cfg_set_count),
        .cfg_ss_base     (cfg_ss_base),
        .cfg_ss_count    (cfg_ss_count),
        .cfg_ss_opt      (cfg_ss_opt),
        .cfg_ss_pindirs  (cfg_ss_pindirs),
        .cfg_sync_bypass (cfg_sync_bypass),
        .out_valid       (out_valid),
        .out_dirs        (out_dirs),
        .out_data        (out_data),
        .set_valid       (set_valid),
        .set_dirs        (set_dirs),
        .set_data        (set_data),
        .ss_valid        (ss_valid),
        .ss_data         (ss_data),
        .pad_in          (pad_in),
        .pad_out         (pad_out),
        .pad_oe          (pad_oe),
        .in_data         (in_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] exp_out;
        logic [31:0] exp_oe;
        logic [31:0] exp_in;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_out;
    logic [31:0] m_oe;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue the state expected after the next active edge.
    task automatic expect_next(input string tag, input logic [31:0] in_exp);
        exp_t e;
        e.tag     = tag;
        e.exp_out = m_out;
        e.exp_oe  = m_oe;
        e.exp_in  = in_exp;
        sb.push_back(e);
    endtask

    // Advance one cycle, sample 1 time unit after the edge, drain the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".pad_out"}, pad_out, e.exp_out);
            chk({e.tag, ".pad_oe"},  pad_oe,  e.exp_oe);
            chk({e.tag, ".in_data"}, in_data, e.exp_in);
        end
    endtask

    task automatic clear_strobes();
        out_valid = 1'b0;
        set_valid = 1'b0;
        ss_valid  = 1'b0;
        out_dirs  = 1'b0;
        set_dirs  = 1'b0;
    endtask

    initial begin
        // idle configuration
        reset_n         = 1'b0;
        cfg_in_base     = '0;
        cfg_in_count    = 6'd32;
        cfg_out_base    = '0;
        cfg_out_count   = '0;
        cfg_set_base    = '0;
        cfg_set_count   = '0;
        cfg_ss_base     = '0;
        cfg_ss_count    = '0;
        cfg_ss_opt      = 1'b0;
        cfg_ss_pindirs  = 1'b0;
        cfg_sync_bypass = '0;
        out_data        = '0;
        set_data        = '0;
        ss_data         = '0;
        pad_in          = '1;
        clear_strobes();
        m_out = 32'h0;
        m_oe  = 32'h0;

        // 1. reset with all pads high, then synchroniser fill
        repeat (2) @(posedge clock);
        #1;
        chk("reset.pad_out", pad_out, 32'h0);
        chk("reset.pad_oe",  pad_oe,  32'h0);
        chk("reset.in_data", in_data, 32'h0);
        reset_n = 1'b1;
        expect_next("fill1", 32'h0);
        step();
        expect_next("fill2", 32'hFFFF_FFFF);
        step();

        // empty IN window, pads quiet from here on
        pad_in       = '0;
        cfg_in_count = 6'd0;
        expect_next("in_cnt0", 32'h0);
        step();

        // 2. OUT wrapping past the top pin
        cfg_out_base  = 5'd30;
        cfg_out_count = 6'd4;
        out_data      = 32'hB;
        out_valid     = 1'b1;
        m_out         = 32'hC000_0002;
        expect_next("out_wrap", 32'h0);
        step();
        out_valid = 1'b0;
        out_data  = 32'hFFFF_FFFF;
        expect_next("out_hold1", 32'h0);
        step();
        expect_next("out_hold2", 32'h0);
        step();

        // 3. side-set > SET > OUT on overlapping pins
        cfg_set_base   = 5'd4;
        cfg_set_count  = 3'd3;
        set_data       = 5'b00000;
        set_valid      = 1'b1;
        cfg_out_base   = 5'd4;
        cfg_out_count  = 6'd3;
        out_data       = 32'h7;
        out_valid      = 1'b1;
        cfg_ss_base    = 5'd5;
        cfg_ss_count   = 3'd1;
        cfg_ss_opt     = 1'b0;
        ss_data        = 5'b00001;
        ss_valid       = 1'b1;
        m_out          = 32'hC000_0022;
        expect_next("priority", 32'h0);
        step();
        clear_strobes();

        // 4. optional side-set: enable low, then enable high
        cfg_ss_opt   = 1'b1;
        cfg_ss_count = 3'd3;
        cfg_ss_base  = 5'd8;
        ss_data      = 5'b00011;
        ss_valid     = 1'b1;
        expect_next("ss_opt_off", 32'h0);
        step();
        ss_data = 5'b00110;
        m_out   = 32'hC000_0222;
        expect_next("ss_opt_on", 32'h0);
        step();
        clear_strobes();

        // 5. SET to pindirs, then OUT to pins
        cfg_set_base  = 5'd2;
        cfg_set_count = 3'd2;
        set_data      = 5'b00011;
        set_dirs      = 1'b1;
        set_valid     = 1'b1;
        m_oe          = 32'h0000_000C;
        expect_next("set_dirs", 32'h0);
        step();
        clear_strobes();
        cfg_out_base  = 5'd0;
        cfg_out_count = 6'd4;
        out_data      = 32'hF;
        out_valid     = 1'b1;
        m_out         = 32'hC000_022F;
        expect_next("out_pins", 32'h0);
        step();
        clear_strobes();

        // OUT to pins and side-set to pindirs in the same cycle both land
        cfg_out_base   = 5'd16;
        cfg_out_count  = 6'd8;
        out_data       = 32'hA5;
        out_valid      = 1'b1;
        cfg_ss_opt     = 1'b0;
        cfg_ss_pindirs = 1'b1;
        cfg_ss_count   = 3'd2;
        cfg_ss_base    = 5'd0;
        ss_data        = 5'b00001;
        ss_valid       = 1'b1;
        m_out          = 32'hC0A5_022F;
        m_oe           = 32'h0000_000D;
        expect_next("split_targets", 32'h0);
        step();
        clear_strobes();
        cfg_ss_pindirs = 1'b0;

        // OUT with count 0 touches nothing
        cfg_out_base  = 5'd0;
        cfg_out_count = 6'd0;
        out_data      = 32'hFFFF_FFFF;
        out_valid     = 1'b1;
        expect_next("out_cnt0", 32'h0);
        step();

        // OUT count 40 saturates to every pin
        cfg_out_base  = 5'd7;
        cfg_out_count = 6'd40;
        out_data      = 32'h0;
        m_out         = 32'h0;
        expect_next("out_sat", 32'h0);
        step();
        clear_strobes();

        // 6. IN window straddling pin 31/0 with pin 31 bypassed
        pad_in          = 32'h8000_0001;
        cfg_in_base     = 5'd31;
        cfg_in_count    = 6'd2;
        cfg_sync_bypass = 32'h8000_0000;
        #1;
        chk("in_bypass_now", in_data, 32'h1);
        expect_next("in_sync1", 32'h1);
        step();
        expect_next("in_sync2", 32'h3);
        step();

        // reset landing together with writes discards them
        cfg_out_base  = 5'd0;
        cfg_out_count = 6'd32;
        out_data      = 32'hFFFF_FFFF;
        out_valid     = 1'b1;
        cfg_set_base  = 5'd0;
        cfg_set_count = 3'd5;
        set_data      = 5'b11111;
        set_dirs      = 1'b1;
        set_valid     = 1'b1;
        reset_n       = 1'b0;
        m_out         = 32'h0;
        m_oe          = 32'h0;
        // synchroniser flops cleared, bypassed pin 31 still visible as bit 0
        expect_next("rst_write", 32'h1);
        step();
        clear_strobes();
        reset_n = 1'b1;
        expect_next("post_rst", 32'h1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
